// File: rtl/gate_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_tree_pkg
// Description : Cell op encoding and width helpers for pipelined_gate_tree.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_tree_pkg;

    typedef enum logic [1:0] {
        OP_ANDXOR = 2'd0,
        OP_MAJ    = 2'd1,
        OP_XOR3   = 2'd2,
        OP_MUX    = 2'd3
    } op_e;

    function automatic int pow3(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 3;
        end
        return r;
    endfunction

    // Bit offset of stage k inside the flat stage bus (stage 0 = input vector).
    function automatic int stage_off(input int levels, input int k);
        int s;
        s = 0;
        for (int j = 0; j < k; j++) begin
            s = s + pow3(levels - j);
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_cell3.sv
`default_nettype none
// ============================================================================
// Module      : gate_cell3
// Description : Combinational 3-input cell with a runtime-selected function.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_cell3
    import gate_tree_pkg::*;
(
    input  logic       a2,
    input  logic       a1,
    input  logic       a0,
    input  logic [1:0] op,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (op_e'(op))
            OP_ANDXOR: y = a2 & (a1 ^ a0);
            OP_MAJ:    y = (a2 & a1) | (a2 & a0) | (a1 & a0);
            OP_XOR3:   y = a2 ^ a1 ^ a0;
            OP_MUX:    y = a2 ? a1 : a0;
            default:   y = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_gate_tree.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_gate_tree
// Description : LEVELS-deep pipelined 3-ary reduction tree with valid/ready
//               backpressure and a completed-handshake counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_gate_tree
    import gate_tree_pkg::*;
#(
    parameter int LEVELS = 2,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [pow3(LEVELS)-1:0]   in_data,
    input  logic [1:0]                in_op,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      out_data,
    output logic [1:0]                out_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          result_count
);

    localparam int c_W     = pow3(LEVELS);
    localparam int c_BUS_W = stage_off(LEVELS, LEVELS + 1);

    // All stage vectors packed back to back; stage k sits at stage_off(LEVELS, k).
    logic [c_BUS_W-1:0]  w_bus;
    logic [LEVELS:0]     w_valid;
    logic [LEVELS+1:1]   w_ready;
    logic [1:0]          w_op [0:LEVELS];
    logic [CNT_W-1:0]    r_count;

    assign w_bus[c_W-1:0] = in_data;
    assign w_valid[0]     = in_valid;
    assign w_op[0]        = in_op;

    always_comb begin
        w_ready             = '0;
        w_ready[LEVELS+1]   = out_ready;
        for (int k = LEVELS; k >= 1; k--) begin
            w_ready[k] = !w_valid[k] | w_ready[k+1];
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int c_IN_W   = pow3(LEVELS - k + 1);
        localparam int c_M      = pow3(LEVELS - k);
        localparam int c_IN_OFF = stage_off(LEVELS, k - 1);
        localparam int c_OUT_OFF = stage_off(LEVELS, k);

        logic [c_IN_W-1:0] w_vin;
        logic [c_M-1:0]    w_next;
        logic [c_M-1:0]    r_data;
        logic              r_valid;
        logic [1:0]        r_op;

        assign w_vin = w_bus[c_IN_OFF +: c_IN_W];

        // Group j takes the j-th triple counted from the MSB and lands in bit j.
        for (genvar j = 0; j < c_M; j++) begin : g_cell
            gate_cell3 u_cell (
                .a2 (w_vin[c_IN_W-1-3*j]),
                .a1 (w_vin[c_IN_W-2-3*j]),
                .a0 (w_vin[c_IN_W-3-3*j]),
                .op (w_op[k-1]),
                .y  (w_next[j])
            );
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_op    <= 2'd0;
                r_data  <= '0;
            end else if (w_ready[k]) begin
                r_valid <= w_valid[k-1];
                r_op    <= w_op[k-1];
                r_data  <= w_next;
            end
        end

        assign w_valid[k]                 = r_valid;
        assign w_op[k]                    = r_op;
        assign w_bus[c_OUT_OFF +: c_M]    = r_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_valid[LEVELS] && out_ready) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign in_ready     = w_ready[1];
    assign out_valid    = w_valid[LEVELS];
    assign out_op       = w_op[LEVELS];
    assign out_data     = w_bus[c_BUS_W-1];
    assign result_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_gate_tree.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_gate_tree
// Description : Scoreboard bench for pipelined_gate_tree (LEVELS=2 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_gate_tree;

    typedef struct packed {
        logic       d;
        logic [1:0] op;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic [8:0]  d2_in_data;
    logic [1:0]  d2_in_op;
    logic        d2_in_valid, d2_in_ready;
    logic        d2_out_data, d2_out_valid, d2_out_ready;
    logic [1:0]  d2_out_op;
    logic [15:0] d2_result_count;

    logic [26:0] d3_in_data;
    logic [1:0]  d3_in_op;
    logic        d3_in_valid, d3_in_ready;
    logic        d3_out_data, d3_out_valid, d3_out_ready;
    logic [1:0]  d3_out_op;
    logic [1:0]  d3_result_count;

    exp_t q2[$];
    exp_t q3[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp2  = 0;
    int   exp3  = 0;
    logic rnd_done;
    logic held_d;
    logic [1:0] held_op;

    pipelined_gate_tree #(.LEVELS(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d2_in_data), .in_op(d2_in_op), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
        .out_data(d2_out_data), .out_op(d2_out_op), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
        .result_count(d2_result_count)
    );

    pipelined_gate_tree #(.LEVELS(3), .CNT_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_data(d3_in_data), .in_op(d3_in_op), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_op(d3_out_op), .out_valid(d3_out_valid), .out_ready(d3_out_ready),
        .result_count(d3_result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: list of bits MSB first; each level folds consecutive triples,
    // and the folded list is read back with the last group as its MSB.
    function automatic logic cell_ref(input bit a, input bit b, input bit c, input logic [1:0] op);
        case (op)
            2'd0:    return a & (b ^ c);
            2'd1:    return (int'(a) + int'(b) + int'(c)) >= 2;
            2'd2:    return a ^ b ^ c;
            default: return a ? b : c;
        endcase
    endfunction

    function automatic logic ref_tree(input logic [26:0] v, input int levels, input logic [1:0] op);
        bit lst[$];
        bit nxt[$];
        int n;
        n = 3 ** levels;
        for (int i = n - 1; i >= 0; i--) lst.push_back(v[i]);
        for (int l = 0; l < levels; l++) begin
            nxt.delete();
            for (int g = 0; g < lst.size() / 3; g++)
                nxt.push_back(cell_ref(lst[3*g], lst[3*g+1], lst[3*g+2], op));
            lst.delete();
            for (int i = nxt.size() - 1; i >= 0; i--) lst.push_back(nxt[i]);
        end
        return lst[0];
    endfunction

    // Monitors: pop on every output handshake seen at the falling edge.
    always @(negedge clk) begin
        if (rst_n && d2_out_valid && d2_out_ready) begin
            if (q2.size() == 0) begin
                check("d2_unexpected_output", 32'(d2_out_valid), 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("d2_out_data", 32'(d2_out_data), 32'(e.d));
                check("d2_out_op", 32'(d2_out_op), 32'(e.op));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && d3_out_valid && d3_out_ready) begin
            if (q3.size() == 0) begin
                check("d3_unexpected_output", 32'(d3_out_valid), 32'd0);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("d3_out_data", 32'(d3_out_data), 32'(e.d));
                check("d3_out_op", 32'(d3_out_op), 32'(e.op));
            end
        end
    end

    // Present a transaction, wait (bounded) for acceptance, push its expectation.
    task automatic send2(input logic [8:0] d, input logic [1:0] op, input logic e);
        int k;
        d2_in_data  = d;
        d2_in_op    = op;
        d2_in_valid = 1'b1;
        for (k = 0; k < 64; k++) begin
            @(negedge clk);
            if (d2_in_ready) break;
            @(posedge clk); #1;
        end
        if (k == 64) begin
            check("d2_accept_timeout", 32'd0, 32'd1);
        end else begin
            q2.push_back('{d: e, op: op});
            exp2++;
            @(posedge clk); #1;
        end
        d2_in_valid = 1'b0;
    endtask

    task automatic send3(input logic [26:0] d, input logic [1:0] op);
        int k;
        d3_in_data  = d;
        d3_in_op    = op;
        d3_in_valid = 1'b1;
        for (k = 0; k < 64; k++) begin
            @(negedge clk);
            if (d3_in_ready) break;
            @(posedge clk); #1;
        end
        if (k == 64) begin
            check("d3_accept_timeout", 32'd0, 32'd1);
        end else begin
            q3.push_back('{d: ref_tree(d, 3, op), op: op});
            exp3++;
            @(posedge clk); #1;
        end
        d3_in_valid = 1'b0;
    endtask

    task automatic drain2();
        d2_out_ready = 1'b1;
        for (int k = 0; k < 200 && q2.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("d2_queue_drained", 32'(q2.size()), 32'd0);
    endtask

    task automatic drain3();
        d3_out_ready = 1'b1;
        for (int k = 0; k < 200 && q3.size() != 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("d3_queue_drained", 32'(q3.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        d2_in_data = '0; d2_in_op = '0; d2_in_valid = 1'b0; d2_out_ready = 1'b1;
        d3_in_data = '0; d3_in_op = '0; d3_in_valid = 1'b0; d3_out_ready = 1'b1;
        rnd_done = 1'b0;
        #1;
        check("rst_out_valid", 32'(d2_out_valid), 32'd0);
        check("rst_out_data", 32'(d2_out_data), 32'd0);
        check("rst_out_op", 32'(d2_out_op), 32'd0);
        check("rst_count", 32'(d2_result_count), 32'd0);
        check("rst_in_ready", 32'(d2_in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single transaction, latency LEVELS, count becomes 1
        send2(9'h146, 2'd0, 1'b1);
        @(negedge clk);
        check("lat_not_early", 32'(d2_out_valid), 32'd0);
        @(negedge clk);
        check("lat_valid_at_2", 32'(d2_out_valid), 32'd1);
        @(negedge clk);
        check("count_after_first", 32'(d2_result_count), 32'd1);
        @(posedge clk); #1;

        // Back-to-back parity, majority, and mixed ops in flight
        send2(9'h146, 2'd2, 1'b0);
        send2(9'h147, 2'd2, 1'b1);
        send2(9'h1FF, 2'd1, 1'b1);
        send2(9'h007, 2'd1, 1'b0);
        send2(9'h146, 2'd3, 1'b0);
        send2(9'h146, 2'd0, 1'b1);
        drain2();
        check("count_after_directed", 32'(d2_result_count), 32'(exp2));

        // Backpressure: 3 streamed inputs against a 5-cycle stall
        @(posedge clk); #1;
        d2_out_ready = 1'b0;
        fork
            begin
                send2(9'h001, 2'd2, 1'b1);
                send2(9'h003, 2'd2, 1'b0);
                send2(9'h007, 2'd2, 1'b1);
            end
            begin
                repeat (3) @(negedge clk);
                held_d  = d2_out_data;
                held_op = d2_out_op;
                check("bp_in_ready_low", 32'(d2_in_ready), 32'd0);
                check("bp_out_valid", 32'(d2_out_valid), 32'd1);
                repeat (2) begin
                    @(negedge clk);
                    check("bp_data_stable", 32'(d2_out_data), 32'(held_d));
                    check("bp_op_stable", 32'(d2_out_op), 32'(held_op));
                    check("bp_in_ready_held", 32'(d2_in_ready), 32'd0);
                end
                @(posedge clk); #1;
                d2_out_ready = 1'b1;
            end
        join
        drain2();
        check("count_after_bp", 32'(d2_result_count), 32'(exp2));

        // Random data/ops with random backpressure and input gaps
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [8:0] d;
                    logic [1:0] op;
                    d  = 9'($urandom);
                    op = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send2(d, op, ref_tree({18'd0, d}, 2, op));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    d2_out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain2();
        check("count_after_random", 32'(d2_result_count), 32'(exp2));

        // Asynchronous reset with two transactions in flight
        d2_out_ready = 1'b0;
        send2(9'h0AA, 2'd1, ref_tree(27'h0AA, 2, 2'd1));
        send2(9'h155, 2'd2, ref_tree(27'h155, 2, 2'd2));
        @(posedge clk); #2;
        rst_n = 1'b0;
        q2.delete();
        exp2 = 0;
        #1;
        check("midrst_out_valid", 32'(d2_out_valid), 32'd0);
        check("midrst_count", 32'(d2_result_count), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("postrst_in_ready", 32'(d2_in_ready), 32'd1);
        d2_out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("postrst_no_stale", 32'(d2_result_count), 32'd0);

        // LEVELS=3, CNT_W=2: 10 random transactions, count wraps to 10 mod 4
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clk); #1;
                    end
                    send3(27'($urandom), 2'($urandom_range(0, 3)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    d3_out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain3();
        check("d3_count_wrap", 32'(d3_result_count), 32'(exp3 % 4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
